// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MULDIV_EARLY_EN: multiplies stop as soon as the remaining multiplier bits are all zero.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [CW-1:0]      count;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               is_div;
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] mul_sum;
    logic               early_exit;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_div    = op_reg[1];
    assign is_signed = op_reg[0];
    assign abs_a     = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign abs_b     = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    // Restoring step: partial remainder shifted left with the next dividend bit brought in.
    assign div_ge    = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opb};
    assign div_diff  = acc[2*WIDTH-2:WIDTH-1] - opb;
    assign mul_sum   = acc + mcand;

`ifdef MULDIV_EARLY_EN
    // Once the bits still to be scanned are zero, the product cannot change any more.
    assign early_exit = !is_div && (opb[WIDTH-1:1] == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign last_iter = (count == CW'(1)) || early_exit;

    assign prod_fix  = neg_res ? -acc : acc;
    assign quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            opb      <= '0;
            acc      <= '0;
            mcand    <= '0;
            count    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        if (!op[2]) begin
                            a_reg  <= a;
                            b_reg  <= b;
                            op_reg <= op[1:0];
                            state  <= S_PREP;
                            busy   <= 1'b1;
                        end else if (op[1:0] == 2'b00) begin
                            hi <= a;
                        end else if (op[1:0] == 2'b01) begin
                            lo <= a;
                        end
                    end
                end
                S_PREP: begin
                    acc      <= is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
                    mcand    <= {{WIDTH{1'b0}}, abs_a};
                    opb      <= abs_b;
                    neg_res  <= is_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    neg_rem  <= is_signed && a_reg[WIDTH-1];
                    div_zero <= (b_reg == '0);
                    count    <= CW'(WIDTH);
                    state    <= S_ITER;
                end
                S_ITER: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        if (div_ge) begin
                            acc <= {div_diff, acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (opb[0]) begin
                            acc <= mul_sum;
                        end
                        mcand <= {mcand[2*WIDTH-2:0], 1'b0};
                        opb   <= {1'b0, opb[WIDTH-1:1]};
                    end
                    if (last_iter) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        // Divide by zero is defined, not trapped: HI echoes the dividend.
                        hi <= a_reg;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32); honours MULDIV_EARLY_EN for latency checks.
module tb_muldiv_seq;
    localparam int W = 32;
    localparam logic [2:0] MULTU = 3'b000, MULT = 3'b001, DIVU = 3'b010, DIV = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;
    int cyc;
    int busy_cnt;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns 1 time unit after the sampling edge.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'b111;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts cycles after the start edge until done; optionally pulses MTHI at cycle inj.
    task automatic wait_done(input int inj, output int c, output int bc);
        c  = 0;
        bc = 0;
        while (c < 100) begin
            @(negedge clk);
            c++;
            start = (c == inj);
            if (c == inj) begin
                op = MTHI;
                a  = 32'h12345678;
            end
            if (done) break;
            if (busy) bc++;
        end
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        @(negedge clk);
        launch(o, av, bv);
        wait_done(0, cyc, busy_cnt);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h done_cycle=%0d", o, av, bv, hi, lo, cyc);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", W'(busy), 0);
        check("reset done", W'(done), 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset = 1'b0;

        // Full-width unsigned multiply with latency and busy window
        run("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        check("multu max done cycle", W'(cyc), 35);
        check("multu max busy cycles", W'(busy_cnt), 34);
        @(negedge clk);
        check("done one pulse", W'(done), 0);

        run("mult -3*7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
`ifdef MULDIV_EARLY_EN
        check("mult -3*7 cycle", W'(cyc), 6);
`else
        check("mult -3*7 cycle", W'(cyc), 35);
`endif
        run("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check("div -7/2 cycle", W'(cyc), 35);
        run("divu 100/0", DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        run("div -7/0", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run("div min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("mult min*min", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

        // MTHI/MTLO in idle: one edge, no done
        @(negedge clk);
        launch(MTHI, 32'h12345678, 32'd0);
        check("mthi hi", hi, 32'h12345678);
        check("mthi busy", W'(busy), 0);
        check("mthi done", W'(done), 0);
        $display("mthi a=0x12345678 -> hi=0x%08h", hi);
        @(negedge clk);
        launch(MTLO, 32'h0BADF00D, 32'd0);
        check("mtlo lo", lo, 32'h0BADF00D);
        check("mtlo hi kept", hi, 32'h12345678);
        $display("mtlo a=0x0badf00d -> lo=0x%08h", lo);

        // MTHI while busy is ignored, then a back-to-back start in the done cycle
        @(negedge clk);
        launch(DIVU, 32'd17, 32'd5);
        wait_done(10, cyc, busy_cnt);
        check("divu 17/5 cycle", W'(cyc), 35);
        check("divu 17/5 hi", hi, 32'd2);
        check("divu 17/5 lo", lo, 32'd3);
        $display("divu 17/5 with mthi at cycle 10 -> hi=0x%08h lo=0x%08h done_cycle=%0d", hi, lo, cyc);
        launch(MULTU, 32'd9, 32'd3);
        wait_done(0, cyc, busy_cnt);
`ifdef MULDIV_EARLY_EN
        check("b2b multu 9*3 cycle", W'(cyc), 5);
`else
        check("b2b multu 9*3 cycle", W'(cyc), 35);
`endif
        check("b2b multu 9*3 hi", hi, 32'd0);
        check("b2b multu 9*3 lo", lo, 32'd27);
        $display("back-to-back multu 9*3 -> hi=0x%08h lo=0x%08h done_cycle=%0d", hi, lo, cyc);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        launch(MTHI, 32'hCAFE0001, 32'd0);
        @(negedge clk);
        launch(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async reset busy", W'(busy), 0);
        check("async reset hi", hi, 0);
        check("async reset lo", lo, 0);
        $display("reset mid-iter -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b0;
        run("after reset multu 9*3", MULTU, 32'd9, 32'd3, 32'd0, 32'd27);
`ifdef MULDIV_EARLY_EN
        check("after reset cycle", W'(cyc), 5);
`else
        check("after reset cycle", W'(cyc), 35);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
